execute_operand_stage: RTL
==========================

# execute_operand_stage

ID/EX pipeline slot that sits directly upstream of the ALU. It accepts one decoded instruction per handshake, holds it, and resolves forwarding from the MEM and WB stages. It detects load-use hazards and presents the final `aluInput1`/`aluInput2`/`aluOp` triple with a valid/ready handshake toward the execute stage. It supports flush, back-pressure, and refresh of forwarded operands while held.

## Interface
Parameters:
- `ADDR_W`, 5: register address width
- `OP_W`, 6: ALU op width (matches the `Vec6` ALU op encoding)

Ports:
- `clk` input 1: clock, rising edge
- `rstN` input 1: asynchronous, active-low reset
- `inValid` input 1: decode offers an instruction
- `inReady` output 1: slot can accept
- `inPc` input 32: instruction PC
- `inRsData` input 32: rs read data
- `inRtData` input 32: rt read data
- `inImm` input 32: already-extended immediate
- `inShamt` input 5: shift amount field
- `inRsAddr` input ADDR_W: rs register address
- `inRtAddr` input ADDR_W: rt register address
- `inDestAddr` input ADDR_W: destination register (0 = none)
- `inAluOp` input OP_W: ALU operation
- `inSrc1Sel` input 2: input1 source. 0 = rs, 1 = zero-extended shamt, 2 = PC+8
- `inSrc2Sel` input 1: input2 source. 0 = rt, 1 = imm
- `flush` input 1: kill held and incoming instruction
- `memWe` input 1: MEM-stage write enable
- `memAddr` input ADDR_W: MEM-stage destination
- `memData` input 32: MEM-stage result
- `memIsLoad` input 1: MEM-stage instruction is a load (data not yet valid)
- `wbWe` input 1: WB-stage write enable
- `wbAddr` input ADDR_W: WB-stage destination
- `wbData` input 32: WB-stage result
- `outValid` output 1: operands valid toward the ALU
- `outReady` input 1: execute stage accepts
- `aluInput1` output 32: ALU operand 1
- `aluInput2` output 32: ALU operand 2
- `aluOp` output OP_W: ALU operation
- `outPc` output 32: held PC
- `outDestAddr` output ADDR_W: held destination
- `outStoreData` output 32: forwarded rt value, for stores

## Operation
- Single-entry slot. State: `full` bit, plus registered payload (pc, rsVal, rtVal, imm, shamt, addrs, op, selects).
- Forwarded value for a source register `a`:
  - a == 0 → 0.
  - else memWe && memAddr == a && !memIsLoad → memData.
  - else wbWe && wbAddr == a → wbData.
  - else stored value.
  - MEM has priority over WB.
- `hazard` = full && memWe && memIsLoad && memAddr != 0 && (memAddr == rsAddr where used || memAddr == rtAddr where used).
  - rs is used when src1Sel == 0.
  - rt is used when src2Sel == 0, or always for `outStoreData`.
- `outValid` = full && !hazard && !flush.
- `fire` = outValid && outReady.
- `inReady` = !full || fire.
- Every cycle `full` is held and not firing, rsVal/rtVal are overwritten with their forwarded values ("refresh"). A WB result that passes while stalled is therefore not lost.
- `aluInput1`:
  - src1Sel 0 → forwarded rs.
  - src1Sel 1 → {27'b0, shamt}.
  - src1Sel 2 → pc + 8.
  - src1Sel 3 → 0.
- `aluInput2`: src2Sel 0 → forwarded rt; src2Sel 1 → imm.
- Capture on inValid && inReady: load payload, `full` ← 1.
- On fire without capture: `full` ← 0.
- flush: `full` ← 0 at the next edge and the incoming instruction is discarded. flush has priority over capture and refresh.
- All arithmetic is 32-bit modulo; PC+8 wraps.

## Timing
- Reset (async, rstN low): `full` = 0. All payload registers = 0. outValid = 0, inReady = 1, aluInput1 = aluInput2 = 0, aluOp = 0, outPc = 0, outDestAddr = 0, outStoreData = 0.
- Reset asserted mid-hold drops the instruction immediately. No output glitch beyond going to reset values.
- Latency: an instruction captured at edge N appears with outValid at N+1 (no hazard).
- Throughput: 1 per cycle with outReady held high (simultaneous fire and capture).
- Load-use: outValid is low for exactly the cycles memIsLoad matches. When the load reaches WB, the value arrives through WB forwarding in the same cycle outValid rises.
- Payload outputs stay stable while outValid && !outReady, except for operand refresh, which cannot change value because sources are identical.
- Simultaneous flush and inValid: inReady may be 1, but nothing is captured.

## Test plan
- Reset with rstN = 0 mid-hold → outValid 0, inReady 1, all outputs 0 immediately, without waiting for a clock edge.
- Capture rs = 3 (data 5), rt = 4 (data 7), src 0/0, op ADD, with memWe = 1, memAddr = 3, memData = 100 → aluInput1 = 100, aluInput2 = 7, outValid 1 edge after capture.
- Load-use: held rs = 8, memIsLoad = 1, memAddr = 8 → outValid 0 for 1 cycle. Next cycle wbAddr = 8, wbData = 0xDEAD → outValid 1, aluInput1 = 0xDEAD.
- Back-pressure: outReady = 0 for 3 cycles while WB writes rt = 9 ← 42 once → held aluInput2 = 42 after release; inReady 0 throughout.
- Back-to-back: 4 instructions with outReady = 1 → one fire per cycle; src1Sel 1 with shamt 31 → aluInput1 = 31; src1Sel 2 with pc 0xFFFFFFFC → aluInput1 = 4.
- flush asserted together with inValid while full → next cycle outValid 0, nothing captured; r0 forwarding always yields 0 even when wbAddr = 0, wbData = 1.

Source files
------------

// File: rtl/execute_operand_stage.sv
// ID/EX operand slot: holds one decoded instruction, resolves MEM/WB forwarding,
// stalls on load-use, and presents ALU operands with a valid/ready handshake.
module execute_operand_stage #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       inPc,
  input  logic [31:0]       inRsData,
  input  logic [31:0]       inRtData,
  input  logic [31:0]       inImm,
  input  logic [4:0]        inShamt,
  input  logic [ADDR_W-1:0] inRsAddr,
  input  logic [ADDR_W-1:0] inRtAddr,
  input  logic [ADDR_W-1:0] inDestAddr,
  input  logic [OP_W-1:0]   inAluOp,
  input  logic [1:0]        inSrc1Sel,
  input  logic              inSrc2Sel,
  input  logic              flush,
  input  logic              memWe,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memData,
  input  logic              memIsLoad,
  input  logic              wbWe,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [31:0]       wbData,
  output logic              outValid,
  input  logic              outReady,
  output logic [31:0]       aluInput1,
  output logic [31:0]       aluInput2,
  output logic [OP_W-1:0]   aluOp,
  output logic [31:0]       outPc,
  output logic [ADDR_W-1:0] outDestAddr,
  output logic [31:0]       outStoreData
);

  logic              full;
  logic [31:0]       pc;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;
  logic [31:0]       imm;
  logic [4:0]        shamt;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [OP_W-1:0]   op;
  logic [1:0]        src1_sel;
  logic              src2_sel;

  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic        hazard;
  logic        fire;
  logic        capture;

  // MEM beats WB; a MEM load has no data yet, so it never forwards.
  always_comb begin
    rs_fwd = rs_val;
    if (rs_addr == '0)
      rs_fwd = '0;
    else if (memWe && !memIsLoad && memAddr == rs_addr)
      rs_fwd = memData;
    else if (wbWe && wbAddr == rs_addr)
      rs_fwd = wbData;
  end

  always_comb begin
    rt_fwd = rt_val;
    if (rt_addr == '0)
      rt_fwd = '0;
    else if (memWe && !memIsLoad && memAddr == rt_addr)
      rt_fwd = memData;
    else if (wbWe && wbAddr == rt_addr)
      rt_fwd = wbData;
  end

  // rt always counts as used because store data is always presented.
  assign hazard = full && memWe && memIsLoad && (memAddr != '0) &&
                  (((src1_sel == 2'd0) && (memAddr == rs_addr)) || (memAddr == rt_addr));

  assign outValid = full && !hazard && !flush;
  assign fire     = outValid && outReady;
  assign inReady  = !full || fire;
  assign capture  = inValid && inReady && !flush;

  always_comb begin
    aluInput1 = '0;
    case (src1_sel)
      2'd0:    aluInput1 = rs_fwd;
      2'd1:    aluInput1 = {27'b0, shamt};
      2'd2:    aluInput1 = pc + 32'd8;
      default: aluInput1 = '0;
    endcase
  end

  assign aluInput2    = src2_sel ? imm : rt_fwd;
  assign aluOp        = op;
  assign outPc        = pc;
  assign outDestAddr  = dest_addr;
  assign outStoreData = rt_fwd;

  // Refresh while held keeps a passing WB result from being lost during a stall.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      full      <= 1'b0;
      pc        <= '0;
      rs_val    <= '0;
      rt_val    <= '0;
      imm       <= '0;
      shamt     <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      dest_addr <= '0;
      op        <= '0;
      src1_sel  <= '0;
      src2_sel  <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (capture) begin
      full      <= 1'b1;
      pc        <= inPc;
      rs_val    <= inRsData;
      rt_val    <= inRtData;
      imm       <= inImm;
      shamt     <= inShamt;
      rs_addr   <= inRsAddr;
      rt_addr   <= inRtAddr;
      dest_addr <= inDestAddr;
      op        <= inAluOp;
      src1_sel  <= inSrc1Sel;
      src2_sel  <= inSrc2Sel;
    end else if (fire) begin
      full <= 1'b0;
    end else if (full) begin
      rs_val <= rs_fwd;
      rt_val <= rt_fwd;
    end
  end

endmodule
